// File: rtl/if_fetch_if.sv
// Instruction-bus bundle between the fetch stage and instruction memory.
// Latency: none, wires only. Backpressure: the slave holds bus_rdy low until the word is valid.
// Ports: bus_req/bus_addr (master -> slave), bus_rdy/bus_rd_data (slave -> master).
interface if_fetch_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rdy;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_rdy,
    input  bus_rd_data
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_rdy,
    output bus_rd_data
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC and drives the IF/ID register (if_pc/if_insn/if_en).
// Latency: bus_rdy in cycle N gives if_en=1 in cycle N+1; one instruction per cycle on a zero-wait bus.
// Backpressure: stall freezes if_*; a word returning during a stall is parked in a one-entry skid buffer.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               hold the IF/ID register, ignore redirects
//   flush / new_pc      restart fetch at new_pc (higher priority than br_taken)
//   br_taken / br_addr  branch redirect from ID
//   bus                 instruction bus (master side): single outstanding request
//   busy                fetch is waiting on the bus this cycle
//   if_pc/if_insn/if_en IF/ID register outputs
//   bus_err             (IF_BUS_TIMEOUT_EN only) one-cycle pulse when a request is abandoned
//
// Optional feature macro: IF_BUS_TIMEOUT_EN adds an 8-bit bus wait counter, the TIMEOUT parameter
// and the bus_err output. Without it the stage waits on the bus indefinitely.
module if_fetch #(
  parameter int                 ADDR_W   = 30,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  NOP_INSN = '0
`ifdef IF_BUS_TIMEOUT_EN
  ,
  parameter int                 TIMEOUT  = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  if_fetch_if.master        bus,
  output logic              busy,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
`ifdef IF_BUS_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  // FETCH: request outstanding at fetch_pc.
  // HOLD : word parked in the skid buffer, no request.
  // DRAIN: an abandoned request is still outstanding at drain_addr; its data is dropped.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_insn_q, skid_insn_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;

  logic waiting;   // a bus request is being presented (FETCH or DRAIN)
  logic tmo_hit;   // request abandoned this cycle by the wait timer
  logic rdy;       // bus completion that is actually accepted
  logic redirect;  // flush or branch taken effect this cycle

  assign waiting  = (state_q != S_HOLD);
  assign rdy      = bus.bus_rdy & ~tmo_hit;
  assign redirect = ~stall & (flush | br_taken);

  // ------------------------------------------------------------------
  // Optional bus wait timer
  // ------------------------------------------------------------------
`ifdef IF_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign tmo_hit = waiting & (wait_cnt_q == TMO_LIMIT);
  assign bus_err = tmo_hit;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (bus.bus_rdy || flush || tmo_hit) begin
      wait_cnt_d = '0;
    end else if (waiting) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Next-state and IF/ID register update
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_insn_d  = skid_insn_q;
    if_pc_d      = if_pc_q;
    if_insn_d    = if_insn_q;
    if_en_d      = if_en_q;

    if (redirect) begin
      if_en_d     = 1'b0;
      if_insn_d   = NOP_INSN;
      if_pc_d     = '0;
      skid_pc_d   = '0;
      skid_insn_d = NOP_INSN;
      fetch_pc_d  = flush ? new_pc : br_addr;
      // A request still in flight must run to completion so the bus
      // address stays stable; remember where it was going.
      if (waiting && !bus.bus_rdy && !tmo_hit) begin
        state_d = S_DRAIN;
        if (state_q == S_FETCH) begin
          drain_addr_d = fetch_pc_q;
        end
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (rdy) begin
            if (stall) begin
              skid_pc_d   = fetch_pc_q;
              skid_insn_d = bus.bus_rd_data;
              state_d     = S_HOLD;
            end else begin
              if_pc_d    = fetch_pc_q;
              if_insn_d  = bus.bus_rd_data;
              if_en_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + 1'b1;
            end
          end else if (!stall) begin
            if_en_d   = 1'b0;
            if_insn_d = NOP_INSN;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_pc_d    = skid_pc_q;
            if_insn_d  = skid_insn_q;
            if_en_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          // fetch_pc already points at the redirect target; just drop the word.
          if (rdy) begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
      // Abandoned request: retry from the same fetch_pc next cycle.
      if (tmo_hit) begin
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      skid_pc_q    <= '0;
      skid_insn_q  <= NOP_INSN;
      if_pc_q      <= '0;
      if_insn_q    <= NOP_INSN;
      if_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_insn_q  <= skid_insn_d;
      if_pc_q      <= if_pc_d;
      if_insn_q    <= if_insn_d;
      if_en_q      <= if_en_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Request drops combinationally in a reset cycle and for the abandon cycle.
  assign bus.bus_req  = waiting & ~reset & ~tmo_hit;
  assign bus.bus_addr = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign busy         = waiting & ~bus.bus_rdy;

  assign if_pc   = if_pc_q;
  assign if_insn = if_insn_q;
  assign if_en   = if_en_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        busy;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  if_fetch_if #(.ADDR_W(30), .DATA_W(32)) bus_if ();

  if_fetch #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .RESET_PC(30'h0),
    .NOP_INSN(32'h0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .flush   (flush),
    .new_pc  (new_pc),
    .br_taken(br_taken),
    .br_addr (br_addr),
    .bus     (bus_if),
    .busy    (busy),
    .if_pc   (if_pc),
    .if_insn (if_insn),
    .if_en   (if_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of word address.
  function automatic logic [31:0] mem(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h0000_0011;
      30'd1:   return 32'h0000_0022;
      30'd2:   return 32'h0000_0033;
      30'd8:   return 32'h0000_00AB;
      default: return 32'h5A00_0000 ^ {2'b00, a};
    endcase
  endfunction

  assign bus_if.bus_rd_data = mem(bus_if.bus_addr);

  int total = 0;
  int bad   = 0;

  // Reference model: program order stream plus the last IF/ID contents.
  logic [29:0] exp_pc;
  logic        m_en;
  logic [29:0] m_pc;
  logic [31:0] m_insn;
  int          deliveries;
  logic        prev_wait;
  logic [29:0] prev_addr;
  logic        obs_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check bus-side rules, clock, check IF/ID against the model.
  task automatic cycle(input logic rst, input logic st, input logic fl, input logic [29:0] npc,
                       input logic br, input logic [29:0] ba, input logic rdy);
    reset = rst; stall = st; flush = fl; new_pc = npc;
    br_taken = br; br_addr = ba; bus_if.bus_rdy = rdy;
    #1;
    obs_busy = busy;
    if (rst) begin
      check("req_in_reset", {31'b0, bus_if.bus_req}, 32'd0);
    end else begin
      check("busy", {31'b0, busy}, {31'b0, bus_if.bus_req & ~rdy});
      if (prev_wait) begin
        check("req_held", {31'b0, bus_if.bus_req}, 32'd1);
        check("addr_held", {2'b0, bus_if.bus_addr}, {2'b0, prev_addr});
      end
    end
    prev_wait = !rst && (bus_if.bus_req === 1'b1) && !rdy;
    prev_addr = bus_if.bus_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_pc = 30'h0; m_en = 1'b0; m_pc = 30'h0; m_insn = NOP;
      check("rst_en", {31'b0, if_en}, 32'd0);
      check("rst_pc", {2'b0, if_pc}, 32'd0);
      check("rst_insn", if_insn, NOP);
    end else if (st) begin
      check("stall_en", {31'b0, if_en}, {31'b0, m_en});
      check("stall_pc", {2'b0, if_pc}, {2'b0, m_pc});
      check("stall_insn", if_insn, m_insn);
    end else if (fl || br) begin
      exp_pc = fl ? npc : ba;
      m_en = 1'b0; m_pc = 30'h0; m_insn = NOP;
      check("redir_en", {31'b0, if_en}, 32'd0);
      check("redir_pc", {2'b0, if_pc}, 32'd0);
      check("redir_insn", if_insn, NOP);
    end else if (if_en === 1'b1) begin
      check("seq_pc", {2'b0, if_pc}, {2'b0, exp_pc});
      check("seq_insn", if_insn, mem(exp_pc));
      m_en = 1'b1; m_pc = exp_pc; m_insn = mem(exp_pc);
      exp_pc = exp_pc + 30'd1;
      deliveries++;
    end else begin
      check("bubble_en", {31'b0, if_en}, 32'd0);
      check("bubble_pc", {2'b0, if_pc}, {2'b0, m_pc});
      check("bubble_insn", if_insn, NOP);
      m_en = 1'b0; m_insn = NOP;
    end
  endtask

  task automatic run(input logic rdy);
    cycle(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, rdy);
  endtask

  initial begin
    logic [29:0] tgt;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = '0;
    br_taken = 1'b0; br_addr = '0; bus_if.bus_rdy = 1'b0;
    exp_pc = 30'h0; m_en = 1'b0; m_pc = 30'h0; m_insn = NOP;
    deliveries = 0; prev_wait = 1'b0; prev_addr = '0; obs_busy = 1'b0;
    @(posedge clk);
    #1;

    // Reset
    cycle(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b1);

    // 1: zero-wait bus from address 0
    run(1'b1);
    check("t1_en", {31'b0, if_en}, 32'd1);
    check("t1_pc0", {2'b0, if_pc}, 32'd0);
    check("t1_insn0", if_insn, 32'h11);
    run(1'b1);
    check("t1_insn1", if_insn, 32'h22);
    run(1'b1);
    check("t1_pc2", {2'b0, if_pc}, 32'd2);
    check("t1_insn2", if_insn, 32'h33);
    check("t1_busy", {31'b0, obs_busy}, 32'd0);

    // 2: three wait cycles at address 5
    run(1'b1);
    run(1'b1);
    check("t2_addr", {2'b0, bus_if.bus_addr}, 32'd5);
    for (int i = 0; i < 3; i++) begin
      run(1'b0);
      check("t2_busy", {31'b0, obs_busy}, 32'd1);
      check("t2_en", {31'b0, if_en}, 32'd0);
      check("t2_insn", if_insn, NOP);
      check("t2_addr_stable", {2'b0, bus_if.bus_addr}, 32'd5);
    end
    run(1'b1);
    check("t2_pc", {2'b0, if_pc}, 32'd5);
    check("t2_en_after", {31'b0, if_en}, 32'd1);

    // 3: word at 8 returns during a 4-cycle stall
    run(1'b1);
    run(1'b1);
    check("t3_addr", {2'b0, bus_if.bus_addr}, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0, 1'b1);
    check("t3_req_hold", {31'b0, bus_if.bus_req}, 32'd0);
    check("t3_frozen_pc", {2'b0, if_pc}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
      check("t3_req_hold", {31'b0, bus_if.bus_req}, 32'd0);
      check("t3_frozen_pc", {2'b0, if_pc}, 32'd7);
    end
    run(1'b0);
    check("t3_pc", {2'b0, if_pc}, 32'd8);
    check("t3_insn", if_insn, 32'hAB);
    check("t3_en", {31'b0, if_en}, 32'd1);
    check("t3_next_addr", {2'b0, bus_if.bus_addr}, 32'd9);

    // 4: flush while waiting on address 3
    cycle(1'b0, 1'b0, 1'b1, 30'h3, 1'b0, 30'h0, 1'b1);
    check("t4_addr3", {2'b0, bus_if.bus_addr}, 32'd3);
    run(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 30'h100, 1'b0, 30'h0, 1'b0);
    check("t4_drain_req", {31'b0, bus_if.bus_req}, 32'd1);
    check("t4_drain_addr", {2'b0, bus_if.bus_addr}, 32'd3);
    run(1'b0);
    run(1'b1);
    check("t4_discard", {31'b0, if_en}, 32'd0);
    check("t4_new_addr", {2'b0, bus_if.bus_addr}, 32'h100);
    run(1'b1);
    check("t4_pc", {2'b0, if_pc}, 32'h100);

    // 5: flush beats branch; branch under stall ignored
    cycle(1'b0, 1'b0, 1'b1, 30'h40, 1'b1, 30'h80, 1'b1);
    check("t5_addr", {2'b0, bus_if.bus_addr}, 32'h40);
    run(1'b1);
    check("t5_pc", {2'b0, if_pc}, 32'h40);
    cycle(1'b0, 1'b1, 1'b0, 30'h0, 1'b1, 30'h80, 1'b0);
    check("t5_br_ignored", {2'b0, bus_if.bus_addr}, 32'h41);
    run(1'b1);
    check("t5_seq_pc", {2'b0, if_pc}, 32'h41);
    check("t5_seq_addr", {2'b0, bus_if.bus_addr}, 32'h42);

    // 6: PC wrap, then reset mid-wait
    cycle(1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0, 30'h0, 1'b1);
    check("t6_top", {2'b0, bus_if.bus_addr}, 32'h3FFF_FFFF);
    run(1'b1);
    check("t6_top_pc", {2'b0, if_pc}, 32'h3FFF_FFFF);
    check("t6_wrap", {2'b0, bus_if.bus_addr}, 32'd0);
    run(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 1'b0);
    check("t6_rst_en", {31'b0, if_en}, 32'd0);
    check("t6_rst_addr", {2'b0, bus_if.bus_addr}, 32'd0);
    run(1'b1);
    check("t6_restart_pc", {2'b0, if_pc}, 32'd0);
    check("t6_restart_insn", if_insn, 32'h11);

    // Randomized traffic against the stream model
    deliveries = 0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
        1:       tgt = 30'($urandom_range(0, 63));
        default: tgt = 30'($urandom);
      endcase
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 5),
            tgt,
            ($urandom_range(0, 99) < 5),
            30'($urandom),
            ($urandom_range(0, 99) < 60));
    end
    check("rand_progress", {31'b0, (deliveries > 300)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
